// File: rtl/fifo_flagged_pkg.sv
// Shared types and helpers for the flagged FIFO.
// Request encoding and depth helper.
package fifo_flagged_pkg;

  // {effective write, effective read}
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  localparam int AW_MIN = 2;
  localparam int AW_MAX = 12;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_flagged_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i, rdata_o.
module fifo_mem #(
  parameter int DATA_SIZE     = 8,
  parameter int ADDR_SIZE_EXP = 4
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [ADDR_SIZE_EXP-1:0] waddr_i,
  input  logic [DATA_SIZE-1:0]     wdata_i,
  input  logic [ADDR_SIZE_EXP-1:0] raddr_i,
  output logic [DATA_SIZE-1:0]     rdata_o
);

  localparam int DEPTH = 1 << ADDR_SIZE_EXP;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_flagged.sv
// Single-clock FWFT FIFO with count, thresholds, sticky errors, flush.
// Ports: CLK, RESET_N, flush, clr_err, wr/rd requests, data, count, flags.
module fifo_flagged
  import fifo_flagged_pkg::*;
#(
  parameter int DATA_SIZE     = 8,
  parameter int ADDR_SIZE_EXP = 4,
  parameter int AFULL_THRESH  = fifo_depth(ADDR_SIZE_EXP) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     flush,
  input  logic                     clr_err,
  input  logic                     wr_to_fifo,
  input  logic [DATA_SIZE-1:0]     wr_data_in,
  input  logic                     rd_from_fifo,
  output logic [DATA_SIZE-1:0]     rd_data_out,
  output logic [ADDR_SIZE_EXP:0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = fifo_depth(ADDR_SIZE_EXP);
  localparam int CW    = ADDR_SIZE_EXP + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

  if (ADDR_SIZE_EXP < AW_MIN || ADDR_SIZE_EXP > AW_MAX) begin : g_bad_aw
    $error("fifo_flagged: ADDR_SIZE_EXP out of range");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_flagged: AFULL_THRESH out of range");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_flagged: AEMPTY_THRESH out of range");
  end

  logic [ADDR_SIZE_EXP-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE_EXP-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic empty_q, full_q, aempty_q, afull_q;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic rd_eff, wr_eff, mem_we;
  op_e  op;

  // A write into a full FIFO is legal when a pop frees the slot.
  assign rd_eff = rd_from_fifo & ~empty_q;
  assign wr_eff = wr_to_fifo & (~full_q | rd_eff);
  assign op     = op_e'({wr_eff, rd_eff});
  assign mem_we = wr_eff & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (op)
      OP_WR: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      OP_RD: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      OP_HOLD: ;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // New errors win over a same-cycle clear; flush swallows requests.
  always_comb begin
    ovf_d = (ovf_q & ~clr_err) | (~flush & wr_to_fifo & ~wr_eff);
    udf_d = (udf_q & ~clr_err) | (~flush & rd_from_fifo & empty_q);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == DEPTH_C);
      aempty_q <= (count_d <= AE_C);
      afull_q  <= (count_d >= AF_C);
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .DATA_SIZE    (DATA_SIZE),
    .ADDR_SIZE_EXP(ADDR_SIZE_EXP)
  ) u_mem (
    .clk_i  (CLK),
    .we_i   (mem_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_data_in),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_data_out)
  );

  assign count        = count_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_flagged.sv
// Directed bench for fifo_flagged with a queue-based scoreboard.
// DEPTH=16, almost_full at >=14, almost_empty at <=2.
module tb_fifo_flagged;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic       wr_to_fifo = 1'b0;
  logic [7:0] wr_data_in = '0;
  logic       rd_from_fifo = 1'b0;
  logic [7:0] rd_data_out;
  logic [4:0] count;
  logic       empty, full, almost_empty, almost_full;
  logic       overflow, underflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  always #5 CLK = ~CLK;

  fifo_flagged dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .flush       (flush),
    .clr_err     (clr_err),
    .wr_to_fifo  (wr_to_fifo),
    .wr_data_in  (wr_data_in),
    .rd_from_fifo(rd_from_fifo),
    .rd_data_out (rd_data_out),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int n;
    n = sb.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == 16));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 2));
    chk({tag, ".afull"}, 32'(almost_full), 32'(n >= 14));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
    if (n > 0) chk({tag, ".data"}, 32'(rd_data_out), 32'(sb[0]));
  endtask

  // One clock with the given requests; scoreboard updated, then checked.
  task automatic cyc(input string tag, input logic w, input logic r,
                     input logic [7:0] d, input logic f, input logic c);
    logic re, we, os, us;
    wr_to_fifo   = w;
    rd_from_fifo = r;
    wr_data_in   = d;
    flush        = f;
    clr_err      = c;
    os = 1'b0;
    us = 1'b0;
    if (f) begin
      sb.delete();
    end else begin
      re = r && (sb.size() > 0);
      we = w && (sb.size() < 16 || re);
      os = w && !we;
      us = r && (sb.size() == 0);
      if (re) void'(sb.pop_front());
      if (we) sb.push_back(d);
    end
    m_ovf = (m_ovf && !c) || os;
    m_udf = (m_udf && !c) || us;
    @(posedge CLK);
    #1;
    wr_to_fifo   = 1'b0;
    rd_from_fifo = 1'b0;
    flush        = 1'b0;
    clr_err      = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    chk_all("post_rel");

    for (int i = 1; i <= 16; i++) cyc("fill", 1, 0, 8'(i), 0, 0);
    cyc("ovf", 1, 0, 8'h77, 0, 0);
    cyc("clr_ovf", 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) cyc("drain", 0, 1, 8'h00, 0, 0);

    cyc("udf", 0, 1, 8'h00, 0, 0);
    cyc("wr_rd_empty", 1, 1, 8'hA5, 0, 0);
    cyc("clr_udf", 0, 0, 8'h00, 0, 1);

    for (int i = 0; i < 15; i++)
      cyc("refill", 1, 0, 8'($urandom_range(0, 255)), 0, 0);
    for (int i = 0; i < 40; i++)
      cyc("both_full", 1, 1, 8'($urandom_range(0, 255)), 0, 0);

    for (int i = 0; i < 7; i++) cyc("to9", 0, 1, 8'h00, 0, 0);
    cyc("flush", 1, 0, 8'hEE, 1, 0);
    cyc("wr3c", 1, 0, 8'h3C, 0, 0);
    cyc("rd3c", 0, 1, 8'h00, 0, 0);
    cyc("udf2", 0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++)
      cyc("fill2", 1, 0, 8'(8'h40 + i), 0, 0);
    cyc("ovf2", 1, 0, 8'h99, 0, 0);
    for (int i = 0; i < 9; i++) cyc("to7", 0, 1, 8'h00, 0, 0);

    #3;
    RESET_N = 1'b0;
    sb.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1;
    chk_all("async_rst");
    @(negedge CLK);
    RESET_N = 1'b1;
    cyc("after_rst", 1, 0, 8'h5A, 0, 0);
    cyc("after_rst_rd", 0, 1, 8'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
